// File: rtl/matmul_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : matmul_result_reader
// Purpose  : Unloads a matrix product from the result memory. Walks read
//            addresses 0..DEPTH-1 over a synchronous read port and streams
//            the returned words on a valid/ready channel. A 4-entry output
//            FIFO absorbs the memory read latency; reads are only issued
//            while a FIFO slot is guaranteed for the returning word, so
//            backpressure never drops or duplicates a word.
// Ports    : clk       - clock, rising edge
//            rst_n     - asynchronous active-low reset
//            start     - one-cycle pulse, begins an unload (only in IDLE)
//            busy      - unload in progress
//            rd_en     - memory read strobe
//            rd_addr   - memory read address
//            rd_data   - memory read data, valid RD_LAT cycles after rd_en
//            out_data  - streamed result word
//            out_valid - out_data valid
//            out_ready - consumer ready
//            out_last  - marks the word with index DEPTH-1
//            done      - one-cycle pulse after the last word is accepted
//            checksum  - wrapping sum of accepted words
// Options  : RESULT_READER_CHECKSUM_EN - when defined, builds the checksum
//            accumulator; otherwise checksum is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_result_reader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam int FIFO_DEPTH = 4;
  // One extra bit so that DEPTH == 2**ADDR_W does not wrap early.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_addr_cnt;
  logic [CNT_W-1:0]  r_emit_cnt;
  logic [2:0]        r_inflight;
  logic [2:0]        r_fifo_count;
  logic [RD_LAT-1:0] r_lat_pipe;
  logic [DATA_W-1:0] r_fifo_mem [FIFO_DEPTH];
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;

  logic       w_cap;
  logic       w_pop;
  logic [3:0] w_credits;
  logic       w_issue;

  assign w_cap = r_lat_pipe[RD_LAT-1];
  assign w_pop = out_valid & out_ready;

  // Credits in use after this edge: every issued read holds a slot from
  // its issue until its word leaves the FIFO. A word popping this cycle
  // frees its slot in time for the read issued at the same edge.
  assign w_credits = {1'b0, r_inflight} + {1'b0, r_fifo_count} - {3'b000, w_pop};
  assign w_issue   = ((r_state == S_IDLE) && start) ||
                     ((r_state == S_READ) && (w_credits < 4'd4));

  // --------------------------------------------------------------------------
  // Control FSM, address/emit counters and registered control outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr_cnt <= '0;
      r_emit_cnt <= '0;
      r_inflight <= '0;
      busy       <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      done       <= 1'b0;
    end else begin
      rd_en      <= 1'b0;
      done       <= 1'b0;
      r_inflight <= r_inflight + {2'b00, w_issue} - {2'b00, w_cap};
      if (w_pop) begin
        r_emit_cnt <= r_emit_cnt + CNT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            rd_en      <= 1'b1;
            rd_addr    <= '0;
            r_addr_cnt <= CNT_W'(1);
            r_emit_cnt <= '0;
            r_state    <= (DEPTH == 1) ? S_DRAIN : S_READ;
          end
        end
        S_READ: begin
          if (w_issue) begin
            rd_en      <= 1'b1;
            rd_addr    <= r_addr_cnt[ADDR_W-1:0];
            r_addr_cnt <= r_addr_cnt + CNT_W'(1);
            if (r_addr_cnt == LAST_IDX) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_pop && (r_emit_cnt == LAST_IDX)) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read-latency delay line: the tap marks the cycle rd_data is valid
  // --------------------------------------------------------------------------
  generate
    if (RD_LAT == 1) begin : g_lat_one
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_lat_pipe <= '0;
        end else begin
          r_lat_pipe <= rd_en;
        end
      end
    end else begin : g_lat_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_lat_pipe <= '0;
        end else begin
          r_lat_pipe <= {r_lat_pipe[RD_LAT-2:0], rd_en};
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
    end else begin
      if (w_cap) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      r_fifo_count <= r_fifo_count + {2'b00, w_cap} - {2'b00, w_pop};
    end
  end

  // Storage needs no reset: the head is gated to zero while empty.
  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_fifo_mem[r_wr_ptr] <= rd_data;
    end
  end

  assign out_valid = (r_fifo_count != 3'd0);
  assign out_data  = out_valid ? r_fifo_mem[r_rd_ptr] : '0;
  assign out_last  = out_valid && (r_emit_cnt == LAST_IDX);

  // --------------------------------------------------------------------------
  // Optional checksum of accepted words
  // --------------------------------------------------------------------------
`ifdef RESULT_READER_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_checksum <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_checksum <= '0;
    end else if (w_pop) begin
      r_checksum <= r_checksum + out_data;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matmul_result_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_result_reader
// Purpose  : Self-checking bench. Two instances (RD_LAT=1 and RD_LAT=2) each
//            read from their own memory model; every stream is compared with
//            the memory contents in address order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matmul_result_reader;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start_a, ready_a, busy_a, rd_en_a, valid_a, last_a, done_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] rdata_a, data_a, csum_a;
  logic          start_b, ready_b, busy_b, rd_en_b, valid_b, last_b, done_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] rdata_b, data_b, csum_b, stage_b;

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];

  matmul_result_reader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .rd_en(rd_en_a),
    .rd_addr(addr_a), .rd_data(rdata_a), .out_data(data_a), .out_valid(valid_a),
    .out_ready(ready_a), .out_last(last_a), .done(done_a), .checksum(csum_a));

  matmul_result_reader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .rd_en(rd_en_b),
    .rd_addr(addr_b), .rd_data(rdata_b), .out_data(data_b), .out_valid(valid_b),
    .out_ready(ready_b), .out_last(last_b), .done(done_b), .checksum(csum_b));

  // Synchronous memories with one and two cycles of read latency.
  always @(posedge clk) if (rd_en_a) rdata_a <= mem_a[addr_a];
  always @(posedge clk) begin
    if (rd_en_b) stage_b <= mem_b[addr_b];
    rdata_b <= stage_b;
  end

  int errors = 0;
  int checks = 0;

  // Observations of the most recent stream.
  logic [DW-1:0] got [64];
  logic [DW-1:0] exp_words [DEPTH];
  logic [DW-1:0] csum_at_done, csum_end, exp_sum;
  int n_words, last_count, last_idx, done_count, done_cycle, last_accept_cycle;
  int first_busy, first_rd, first_valid, stable_viol, credit_viol, addr_viol;
  int n_reads, reads_early, reads_after_done, bubbles, max_addr;
  logic busy_at_done;

  // Reference: stream = memory contents in address order, checksum = their sum.
  task automatic build_expected(input int sel);
    exp_sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_words[i] = (sel == 0) ? mem_a[i] : mem_b[i];
      exp_sum      = exp_sum + exp_words[i];
    end
`ifndef RESULT_READER_CHECKSUM_EN
    exp_sum = '0;
`endif
  endtask

  // Drives one unload and records what happened; comparisons live in tests.
  // mode: 0 ready=1, 1 ready pattern 1,0,0,1, 2 ready=0 through cycle stall, 3 random.
  task automatic run_stream(input int sel, input int mode, input int stall, input bit poke);
    bit            prev_stall = 1'b0;
    bit            seen_done  = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    int            popped = 0;
    int            tail   = 0;
    logic          v, l, b, re, d, rdy, st;
    logic [DW-1:0] od, cs;
    logic [AW-1:0] ra;
    n_words = 0; last_count = 0; last_idx = -1; done_count = 0; done_cycle = -1;
    last_accept_cycle = -1; first_busy = -1; first_rd = -1; first_valid = -1;
    stable_viol = 0; credit_viol = 0; addr_viol = 0; n_reads = 0; reads_early = 0;
    reads_after_done = 0; bubbles = 0; max_addr = -1; busy_at_done = 1'b1;
    csum_at_done = '1; cs = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      if (sel == 0) begin
        v = valid_a; l = last_a; b = busy_a; re = rd_en_a; d = done_a; od = data_a; cs = csum_a; ra = addr_a;
      end else begin
        v = valid_b; l = last_b; b = busy_b; re = rd_en_b; d = done_b; od = data_b; cs = csum_b; ra = addr_b;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2:       rdy = (cyc > stall);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (b && first_busy < 0) first_busy = cyc;
      if (re) begin
        if (first_rd < 0) first_rd = cyc;
        if (int'(ra) != n_reads) addr_viol++;
        n_reads++;
        if (n_reads - popped > 4) credit_viol++;
        if (cyc <= stall) reads_early++;
        if (seen_done) reads_after_done++;
        if (int'(ra) > max_addr) max_addr = int'(ra);
      end
      if (prev_stall && (!v || od !== prev_data)) stable_viol++;
      if (v && first_valid < 0) first_valid = cyc;
      if (d) begin
        done_count++;
        if (!seen_done) begin
          done_cycle = cyc; busy_at_done = b; csum_at_done = cs;
        end
        seen_done = 1'b1;
      end
      if (v && rdy) begin
        if (n_words < 64) got[n_words] = od;
        if (l) begin last_count++; last_idx = n_words; end
        n_words++;
        popped++;
        last_accept_cycle = cyc;
      end else if (rdy && !v && n_words > 0 && n_words < DEPTH) begin
        bubbles++;
      end
      prev_stall = v && !rdy;
      prev_data  = od;
      st = (cyc == 0) || (poke && (cyc == 6 || d));
      if (sel == 0) begin start_a = st; ready_a = rdy; end
      else          begin start_b = st; ready_b = rdy; end
      if (seen_done) begin
        tail++;
        if (tail > 8) break;
      end
    end
    csum_end = cs;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic fill_linear();
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = DW'(3 * i);
      mem_b[i] = DW'(3 * i);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({busy_a, rd_en_a, addr_a, data_a, valid_a, last_a, done_a, csum_a} !== '0) begin
      errors++;
      $display("FAIL reset_lat1: got busy=%b rd_en=%b addr=%0d data=%0d valid=%b last=%b done=%b csum=%0d, want all 0",
               busy_a, rd_en_a, addr_a, data_a, valid_a, last_a, done_a, csum_a);
    end
    checks++;
    if ({busy_b, rd_en_b, addr_b, data_b, valid_b, last_b, done_b, csum_b} !== '0) begin
      errors++;
      $display("FAIL reset_lat2: got busy=%b rd_en=%b addr=%0d data=%0d valid=%b last=%b done=%b csum=%0d, want all 0",
               busy_b, rd_en_b, addr_b, data_b, valid_b, last_b, done_b, csum_b);
    end
  endtask

  task automatic test_basic();
    fill_linear();
    build_expected(0);
    run_stream(0, 0, 0, 1'b0);
    checks++; if (n_words !== DEPTH) begin errors++; $display("FAIL basic_count: got %0d want %0d", n_words, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (got[i] !== exp_words[i]) begin errors++; $display("FAIL basic_word[%0d]: got %0d want %0d", i, got[i], exp_words[i]); end
    end
    checks++; if (first_busy !== 1) begin errors++; $display("FAIL basic_busy_cycle: got %0d want 1", first_busy); end
    checks++; if (first_rd !== 1) begin errors++; $display("FAIL basic_rd_cycle: got %0d want 1", first_rd); end
    checks++; if (first_valid !== 3) begin errors++; $display("FAIL basic_first_valid: got %0d want 3", first_valid); end
    checks++; if (bubbles !== 0) begin errors++; $display("FAIL basic_bubbles: got %0d want 0", bubbles); end
    checks++; if (last_count !== 1 || last_idx !== DEPTH - 1) begin errors++; $display("FAIL basic_last: got count=%0d idx=%0d want 1 and %0d", last_count, last_idx, DEPTH - 1); end
    checks++; if (done_count !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_count); end
    checks++; if (done_cycle !== last_accept_cycle + 1) begin errors++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cycle, last_accept_cycle + 1); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); end
    checks++; if (csum_at_done !== exp_sum) begin errors++; $display("FAIL basic_checksum: got %0d want %0d", csum_at_done, exp_sum); end
    checks++; if (csum_end !== exp_sum) begin errors++; $display("FAIL basic_checksum_hold: got %0d want %0d", csum_end, exp_sum); end
    checks++; if (max_addr !== DEPTH - 1 || n_reads !== DEPTH || addr_viol !== 0) begin errors++; $display("FAIL basic_addr_walk: got max=%0d reads=%0d bad=%0d want %0d %0d 0", max_addr, n_reads, addr_viol, DEPTH - 1, DEPTH); end
  endtask

  task automatic test_backpressure();
    fill_linear();
    build_expected(0);
    run_stream(0, 1, 0, 1'b0);
    checks++; if (n_words !== DEPTH) begin errors++; $display("FAIL bp_count: got %0d want %0d", n_words, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (got[i] !== exp_words[i]) begin errors++; $display("FAIL bp_word[%0d]: got %0d want %0d", i, got[i], exp_words[i]); end
    end
    checks++; if (stable_viol !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stable_viol); end
    checks++; if (credit_viol !== 0) begin errors++; $display("FAIL bp_credit: got %0d over-issues want 0", credit_viol); end
    checks++; if (done_count !== 1) begin errors++; $display("FAIL bp_done_count: got %0d want 1", done_count); end
    checks++; if (csum_at_done !== exp_sum) begin errors++; $display("FAIL bp_checksum: got %0d want %0d", csum_at_done, exp_sum); end
  endtask

  task automatic test_lat2_stall();
    fill_linear();
    build_expected(1);
    run_stream(1, 2, 20, 1'b0);
    checks++; if (reads_early !== 4) begin errors++; $display("FAIL lat2_stall_reads: got %0d want 4", reads_early); end
    checks++; if (addr_viol !== 0 || n_reads !== DEPTH) begin errors++; $display("FAIL lat2_addr_order: got bad=%0d reads=%0d want 0 %0d", addr_viol, n_reads, DEPTH); end
    checks++; if (n_words !== DEPTH) begin errors++; $display("FAIL lat2_stall_count: got %0d want %0d", n_words, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (got[i] !== exp_words[i]) begin errors++; $display("FAIL lat2_stall_word[%0d]: got %0d want %0d", i, got[i], exp_words[i]); end
    end
    checks++; if (stable_viol !== 0) begin errors++; $display("FAIL lat2_stall_stable: got %0d want 0", stable_viol); end
    checks++; if (done_count !== 1) begin errors++; $display("FAIL lat2_stall_done: got %0d want 1", done_count); end
  endtask

  task automatic test_lat2_stream();
    fill_linear();
    build_expected(1);
    run_stream(1, 0, 0, 1'b0);
    checks++; if (first_valid !== 4) begin errors++; $display("FAIL lat2_first_valid: got %0d want 4", first_valid); end
    checks++; if (bubbles !== 0) begin errors++; $display("FAIL lat2_bubbles: got %0d want 0", bubbles); end
    checks++; if (n_words !== DEPTH || last_idx !== DEPTH - 1) begin errors++; $display("FAIL lat2_stream: got words=%0d last=%0d want %0d %0d", n_words, last_idx, DEPTH, DEPTH - 1); end
    checks++; if (done_cycle !== last_accept_cycle + 1) begin errors++; $display("FAIL lat2_done_cycle: got %0d want %0d", done_cycle, last_accept_cycle + 1); end
    checks++; if (csum_at_done !== exp_sum) begin errors++; $display("FAIL lat2_checksum: got %0d want %0d", csum_at_done, exp_sum); end
  endtask

  task automatic test_start_while_busy();
    fill_linear();
    build_expected(0);
    run_stream(0, 0, 0, 1'b1);
    checks++; if (n_words !== DEPTH) begin errors++; $display("FAIL swb_count: got %0d want %0d", n_words, DEPTH); end
    checks++; if (done_count !== 1) begin errors++; $display("FAIL swb_done_count: got %0d want 1", done_count); end
    checks++; if (n_reads !== DEPTH || reads_after_done !== 0) begin errors++; $display("FAIL swb_reads: got %0d (after done %0d) want %0d (0)", n_reads, reads_after_done, DEPTH); end
    checks++; if (got[0] !== exp_words[0] || got[DEPTH-1] !== exp_words[DEPTH-1]) begin errors++; $display("FAIL swb_words: got %0d..%0d want %0d..%0d", got[0], got[DEPTH-1], exp_words[0], exp_words[DEPTH-1]); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      int sel;
      sel = int'($urandom_range(0, 1));
      for (int i = 0; i < DEPTH; i++) begin
        if (sel == 0) mem_a[i] = DW'($urandom);
        else          mem_b[i] = DW'($urandom);
      end
      build_expected(sel);
      run_stream(sel, 3, 0, 1'b0);
      checks++; if (n_words !== DEPTH) begin errors++; $display("FAIL rand%0d_count: got %0d want %0d", it, n_words, DEPTH); end
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (got[i] !== exp_words[i]) begin errors++; $display("FAIL rand%0d_word[%0d]: got %0h want %0h", it, i, got[i], exp_words[i]); end
      end
      checks++; if (stable_viol !== 0 || credit_viol !== 0) begin errors++; $display("FAIL rand%0d_flow: got stable=%0d credit=%0d want 0 0", it, stable_viol, credit_viol); end
      checks++; if (csum_at_done !== exp_sum) begin errors++; $display("FAIL rand%0d_checksum: got %0h want %0h", it, csum_at_done, exp_sum); end
    end
  endtask

  task automatic test_reset_mid();
    int  shown = 0;
    bool_hit: begin end
    fill_linear();
    @(posedge clk); #1;
    start_a = 1'b1; ready_a = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
      if (valid_a) begin
        if (shown == 7) break;
        shown++;
      end
    end
    checks++; if (data_a !== DW'(21)) begin errors++; $display("FAIL rmid_word7: got %0d want 21", data_a); end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({valid_a, busy_a, rd_en_a, done_a} !== 4'b0000) begin
        errors++;
        $display("FAIL rmid_in_reset: got valid=%b busy=%b rd_en=%b done=%b want 0", valid_a, busy_a, rd_en_a, done_a);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    build_expected(0);
    run_stream(0, 0, 0, 1'b0);
    checks++; if (got[0] !== DW'(0)) begin errors++; $display("FAIL rmid_first: got %0d want 0", got[0]); end
    checks++; if (n_words !== DEPTH || done_count !== 1) begin errors++; $display("FAIL rmid_stream: got words=%0d done=%0d want %0d 1", n_words, done_count, DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (got[i] !== exp_words[i]) begin errors++; $display("FAIL rmid_word[%0d]: got %0d want %0d", i, got[i], exp_words[i]); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; ready_a = 1'b0;
    start_b = 1'b0; ready_b = 1'b0;
    fill_linear();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_backpressure();
    test_lat2_stall();
    test_lat2_stream();
    test_start_while_busy();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
